// File: rtl/spi_host_cmd_arb.sv
// spi_host_cmd_arb
//
// Round-robin arbiter and beat sequencer for the SPI host TX word path.
// Requesters post a byte length. One requester is granted at a time. The
// grant is issued as ceil(len / WordBytes) word beats on a valid/ready
// handshake toward the TX FIFO write port. The final partial word carries
// trimmed byte enables.
//
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   req_i         per-requester transfer request (level)
//   len_i         per-requester byte count, requester r at [r*LenW +: LenW]
//   gnt_o         registered one-hot grant
//   gnt_idx_o     index of the granted requester
//   busy_o        high while a transfer is in XFER or DONE
//   word_valid_o  beat valid toward the TX FIFO
//   word_ready_i  TX FIFO accepts the beat
//   word_be_o     byte enables of the current beat
//   word_last_o   current beat is the final beat
//   done_o        one-cycle completion pulse
//   abort_o       qualifies done_o: the transfer ended early
`timescale 1ns/1ps

module spi_host_cmd_arb #(
  parameter int NumReq    = 4,
  parameter int LenW      = 9,
  parameter int WordBytes = 4,
  // Derived widths. These are equal to vbits(NumReq) and to
  // vbits(ceil_div(2**LenW-1, WordBytes)+1). The argument of the second
  // expression is always >= 2, so $clog2 alone gives the correct value.
  parameter int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int BeatW     = $clog2((((2**LenW) - 1) + WordBytes - 1) / WordBytes + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_i,
  input  logic [NumReq*LenW-1:0] len_i,
  output logic [NumReq-1:0]      gnt_o,
  output logic [IdxW-1:0]        gnt_idx_o,
  output logic                   busy_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic [WordBytes-1:0]   word_be_o,
  output logic                   word_last_o,
  output logic                   done_o,
  output logic                   abort_o
);

  localparam int ByteShift = (WordBytes > 1) ? $clog2(WordBytes) : 0;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e            state_reg, state_next;
  logic [IdxW-1:0]   rr_ptr_reg;
  logic [IdxW-1:0]   idx_reg;
  logic [LenW-1:0]   len_reg;
  logic [BeatW-1:0]  beats_reg;
  logic [NumReq-1:0] gnt_reg;
  logic              abort_reg;

  logic              grant_en, beat_fire, set_abort;
  logic              found;
  logic [IdxW:0]     cand_ext;
  logic [IdxW-1:0]   winner;
  logic [LenW-1:0]   win_len;
  logic [LenW:0]     len_round;
  logic [BeatW-1:0]  win_beats;
  logic [LenW-1:0]   rem;
  logic [WordBytes-1:0] last_be;
  logic              is_xfer, last_beat;

  // Unpack the flat length bus so the winner can select its field directly.
  logic [LenW-1:0] len_arr [NumReq];
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_len
      assign len_arr[gi] = len_i[gi*LenW +: LenW];
    end
  endgenerate

  // Round-robin search starting at rr_ptr. The extra bit on cand_ext keeps
  // rr_ptr+i from wrapping before the explicit modulo-NumReq fold.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_ext = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand_ext = {1'b0, rr_ptr_reg} + (IdxW+1)'(i);
      if (cand_ext >= (IdxW+1)'(NumReq)) cand_ext = cand_ext - (IdxW+1)'(NumReq);
      if (!found && req_i[cand_ext[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = cand_ext[IdxW-1:0];
      end
    end
  end

  assign win_len   = len_arr[winner];
  assign len_round = {1'b0, win_len} + (LenW+1)'(WordBytes - 1);
  assign win_beats = BeatW'(len_round >> ByteShift);

  // FSM next-state and control strobes.
  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    beat_fire  = 1'b0;
    set_abort  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_en   = 1'b1;
          state_next = (win_len != '0) ? XFER : DONE;
        end
      end
      XFER: begin
        // A dropped request ends the transfer without moving a beat.
        if (!req_i[idx_reg]) begin
          set_abort  = 1'b1;
          state_next = DONE;
        end else if (word_ready_i) begin
          beat_fire = 1'b1;
          if (beats_reg == BeatW'(1)) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      idx_reg    <= '0;
      len_reg    <= '0;
      beats_reg  <= '0;
      gnt_reg    <= '0;
      abort_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_en) begin
        idx_reg   <= winner;
        len_reg   <= win_len;
        beats_reg <= win_beats;
        gnt_reg   <= NumReq'(1) << winner;
        abort_reg <= 1'b0;
      end
      if (beat_fire) beats_reg <= beats_reg - BeatW'(1);
      if (set_abort) abort_reg <= 1'b1;
      if (state_reg == DONE) begin
        gnt_reg    <= '0;
        rr_ptr_reg <= (idx_reg == IdxW'(NumReq - 1)) ? '0 : idx_reg + IdxW'(1);
      end
    end
  end

  // Final-beat byte enables: the low rem bytes, or all bytes when the
  // length is a whole number of words.
  assign rem = len_reg & LenW'(WordBytes - 1);
  generate
    for (genvar gi = 0; gi < WordBytes; gi++) begin : g_be
      assign last_be[gi] = (rem == '0) || (LenW'(gi) < rem);
    end
  endgenerate

  assign is_xfer      = (state_reg == XFER);
  assign last_beat    = (beats_reg == BeatW'(1));
  assign word_valid_o = is_xfer & req_i[idx_reg];
  assign word_last_o  = is_xfer & last_beat;
  assign word_be_o    = !is_xfer ? '0 : (last_beat ? last_be : '1);
  assign gnt_o        = gnt_reg;
  assign gnt_idx_o    = idx_reg;
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = (state_reg == DONE);
  assign abort_o      = done_o & abort_reg;

endmodule

// File: doc/spi_host_cmd_arb.md
Name: spi_host_cmd_arb

Overview:
- Round-robin arbiter and beat sequencer that shares the SPI host TX word path among N requesters.
- Each requester posts a byte-length transfer. The block grants one requester at a time and issues ceil_div(len, WordBytes) word beats on a valid/ready interface, with byte enables on the final partial word.
- It sits between the SPI host command sources and the TX FIFO write port.
- Index and counter widths are derived with vbits and ceil_div from prim_util_pkg.

Parameters:
- NumReq, 4: number of requesters, >=1.
- LenW, 9: width of the per-requester byte-length field.
- WordBytes, 4: bytes per TX word, power of two >=1.
- IdxW, vbits(NumReq): requester index width (derived; do not override).
- BeatW, vbits(ceil_div(2**LenW-1, WordBytes)+1): beat counter width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  NumReq  per-requester transfer request (level).
- len_i  in  NumReq*LenW  per-requester byte count; requester r occupies bits [r*LenW +: LenW].
- gnt_o  out  NumReq  one-hot grant, registered.
- gnt_idx_o  out  IdxW  index of the granted requester.
- busy_o  out  1  high in XFER or DONE.
- word_valid_o  out  1  beat valid toward the TX FIFO.
- word_ready_i  in  1  TX FIFO accepts the beat.
- word_be_o  out  WordBytes  byte enables of the current beat.
- word_last_o  out  1  current beat is the final beat.
- done_o  out  1  one-cycle completion pulse.
- abort_o  out  1  qualifies done_o: the transfer ended early.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, gnt_o=0, gnt_idx_o=0, busy_o=0, word_valid_o=0, word_be_o=0, word_last_o=0, done_o=0, abort_o=0, beat counter=0, latched len=0.
- Reset mid-transfer returns to IDLE immediately. The interrupted transfer is dropped and no done_o is generated.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If any req_i bit is set, the winner is the first set bit searching rr_ptr, rr_ptr+1, ... modulo NumReq.
  - Latch winner index and len_i[winner]. Set beats = ceil_div(len, WordBytes).
  - Next state is XFER if len != 0, else DONE with abort_o=0.
  - gnt_o[winner] and busy_o go high on the next cycle, so grant latency is 1 cycle from request.
- XFER:
  - word_valid_o = req_i[winner], combinational.
  - A beat transfers when word_valid_o & word_ready_i. On each transfer, beats decrements.
  - word_last_o = (beats == 1).
  - word_be_o is all-ones except on the last beat. The last beat enables the low rem bytes, where rem = len % WordBytes; rem==0 means all-ones.
  - On a transfer with beats==1, go to DONE with abort_o=0.
  - If req_i[winner] is low in XFER, no transfer occurs that cycle; go to DONE with abort_o=1.
- DONE:
  - done_o=1 for exactly one cycle, abort_o valid alongside it.
  - gnt_o clears on exit.
  - rr_ptr = (winner+1) mod NumReq, wrapping at NumReq-1 to 0.
  - Always return to IDLE; no back-to-back grant from DONE. Minimum turnaround is 2 idle-grant cycles.
- Requester contract:
  - Hold len_i stable while granted; a len_i change after latch is ignored.
  - A requester that keeps req_i high after done_o re-arbitrates fairly behind the others.
- NumReq==1: IdxW=1, rr_ptr stays 0.
- Maximum len: 2**LenW-1 gives beats = ceil_div(511,4) = 128 with the defaults. The beat counter must not overflow.
- word_ready_i is ignored outside XFER.

Test Plan:
- Single requester: req_i=0001, len=10, word_ready_i=1. Expect gnt_o=0001 the cycle after the request, then 3 beats with word_be_o=1111,1111,0011. word_last_o is high on beat 3 only. done_o pulses the next cycle with abort_o=0.
- Round robin: req_i=1111 held, all len=4. Expect grant order 0,1,2,3,0, one beat each with be=1111, and rr_ptr wrapping from 3 to 0.
- Backpressure: len=8, word_ready_i toggles 0,1,0,0,1. Expect word_valid_o held high, beats advancing only on ready=1, and word_be_o/word_last_o stable while stalled.
- Zero length: req_i=0100, len=0. Expect gnt_o=0100 for one cycle, no word_valid_o, done_o with abort_o=0, and next rr_ptr=3.
- Abort: len=16, the granted requester drops req after 2 beats. Expect word_valid_o low the same cycle, then done_o=1 with abort_o=1 the next cycle, and grant released.
- Async reset mid-XFER: assert rst_i between clock edges. Expect all outputs zero immediately, no done_o, and the first grant after reset going to requester 0.
